// File: rtl/hex_letter_entry.sv
// hex_letter_entry: multi-slot letter entry for the seven-segment displays.
// KEY[0] = next letter, KEY[1] = previous letter, KEY[2] = cursor advance.
// All keys are active-low; each one is synchronised and debounced.
// Optional feature: define CURSOR_BLINK_EN to blink the digit under the cursor.
module hex_letter_entry #(
   parameter  int unsigned DIGITS          = 4,
   parameter  int unsigned DEBOUNCE_CYCLES = 500000,
   parameter  int unsigned BLINK_CYCLES    = 12500000,
   localparam int unsigned CW              = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic                  CLOCK_50,
   input  logic                  RESET,
   input  logic [2:0]            KEY,
   output logic [7*DIGITS-1:0]   HEX,
   output logic [5*DIGITS-1:0]   CODES,
   output logic [CW-1:0]         CURSOR
);

   localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES);

   logic [2:0]                r_sync1;
   logic [2:0]                r_sync2;
   logic [2:0]                r_deb;      // 1 = pressed
   logic [2:0][DBW-1:0]       r_cnt;
   logic [2:0]                r_pulse;
   logic [DIGITS-1:0][4:0]    r_slot;
   logic [CW-1:0]             r_cur;
   logic                      w_inc;
   logic                      w_dec;
   logic                      w_blank;

   // Code 0 is blank; 1..25 run A..Z without K. Segment a lands in bit 0.
   function automatic logic [6:0] f_glyph(input logic [4:0] code);
      logic [0:6] s;  // written a..g, left to right
      logic [6:0] g;
      case (code)
         5'd1:    s = 7'b0001000;
         5'd2:    s = 7'b1100000;
         5'd3:    s = 7'b0110001;
         5'd4:    s = 7'b1000010;
         5'd5:    s = 7'b0110000;
         5'd6:    s = 7'b0111000;
         5'd7:    s = 7'b0100000;
         5'd8:    s = 7'b1001000;
         5'd9:    s = 7'b1001111;
         5'd10:   s = 7'b1000011;
         5'd11:   s = 7'b1110001;
         5'd12:   s = 7'b0101011;
         5'd13:   s = 7'b1101010;
         5'd14:   s = 7'b0000001;
         5'd15:   s = 7'b0011000;
         5'd16:   s = 7'b0001100;
         5'd17:   s = 7'b1111010;
         5'd18:   s = 7'b0100100;
         5'd19:   s = 7'b1110000;
         5'd20:   s = 7'b1000001;
         5'd21:   s = 7'b1100011;
         5'd22:   s = 7'b1010101;
         5'd23:   s = 7'b1001000;
         5'd24:   s = 7'b1000100;
         5'd25:   s = 7'b0010010;
         default: s = 7'b1111111;
      endcase
      for (int unsigned i = 0; i < 7; i++) g[i] = s[i];
      return g;
   endfunction

   function automatic logic [4:0] f_next(input logic [4:0] c);
      return (c >= 5'd25) ? 5'd1 : c + 5'd1;
   endfunction

   function automatic logic [4:0] f_prev(input logic [4:0] c);
      return (c <= 5'd1) ? 5'd25 : c - 5'd1;
   endfunction

   // Synchronise, debounce and emit a one-cycle pulse on each accepted press.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
         r_deb   <= '0;
         r_cnt   <= '0;
         r_pulse <= '0;
      end else begin
         r_sync1 <= KEY;
         r_sync2 <= r_sync1;
         r_pulse <= '0;
         for (int unsigned k = 0; k < 3; k++) begin
            if (~r_sync2[k] != r_deb[k]) begin
               if (r_cnt[k] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                  r_deb[k]   <= ~r_sync2[k];
                  r_cnt[k]   <= '0;
                  r_pulse[k] <= ~r_sync2[k];
               end else begin
                  r_cnt[k] <= r_cnt[k] + DBW'(1);
               end
            end else begin
               r_cnt[k] <= '0;
            end
         end
      end
   end

   // Opposing letter pulses cancel; the cursor pulse is independent.
   always_comb begin
      w_inc = r_pulse[0] & ~r_pulse[1];
      w_dec = r_pulse[1] & ~r_pulse[0];
   end

   // Letter edit on the current slot, then cursor advance.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         r_slot <= '0;
         r_cur  <= '0;
      end else begin
         if (w_inc)      r_slot[r_cur] <= f_next(r_slot[r_cur]);
         else if (w_dec) r_slot[r_cur] <= f_prev(r_slot[r_cur]);
         if (r_pulse[2])
            r_cur <= (r_cur == CW'(DIGITS - 1)) ? '0 : r_cur + CW'(1);
      end
   end

`ifdef CURSOR_BLINK_EN
   localparam int unsigned BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

   logic [BW-1:0] r_bcnt;
   logic          r_vis;
   logic          r_act1;
   logic          r_act2;

   // Blink phase timer; the action pulse is delayed to line up with the HEX update.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         r_bcnt <= '0;
         r_vis  <= 1'b1;
         r_act1 <= 1'b0;
         r_act2 <= 1'b0;
      end else begin
         r_act1 <= |r_pulse;
         r_act2 <= r_act1;
         if (r_act2) begin
            r_bcnt <= '0;
            r_vis  <= 1'b1;
         end else if (r_bcnt == BW'(BLINK_CYCLES - 1)) begin
            r_bcnt <= '0;
            r_vis  <= ~r_vis;
         end else begin
            r_bcnt <= r_bcnt + BW'(1);
         end
      end
   end

   // Blank the cursor digit in the off phase, unless an action is landing now.
   always_comb begin
      w_blank = ~r_vis & ~r_act2;
   end
`else
   // No blinking: every digit is always shown.
   always_comb begin
      w_blank = 1'b0;
   end
`endif

   // Registered outputs: CODES/CURSOR from slot state, HEX one stage later.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         CODES  <= '0;
         CURSOR <= '0;
         HEX    <= '1;
      end else begin
         CODES  <= r_slot;
         CURSOR <= r_cur;
         for (int unsigned d = 0; d < DIGITS; d++) begin
            if (w_blank && (CW'(d) == CURSOR)) HEX[7*d +: 7] <= '1;
            else                               HEX[7*d +: 7] <= f_glyph(CODES[5*d +: 5]);
         end
      end
   end

endmodule

// File: tb/tb_hex_letter_entry.sv
// Bench for hex_letter_entry with DIGITS=2, DEBOUNCE_CYCLES=4, BLINK_CYCLES=8.
// Define CURSOR_BLINK_EN to exercise the blink path.
module tb_hex_letter_entry;

   localparam int DIG = 2;
   localparam int DB  = 4;
   localparam int BL  = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [2:0]        key;
   logic [7*DIG-1:0]  hex;
   logic [5*DIG-1:0]  codes;
   logic [0:0]        cursor;

   int errors = 0;
   int checks = 0;
   int m_slot[DIG];
   int m_cur;

   // Glyphs as a..g strings, index = letter code.
   string GL[26] = '{"1111111", "0001000", "1100000", "0110001", "1000010",
                     "0110000", "0111000", "0100000", "1001000", "1001111",
                     "1000011", "1110001", "0101011", "1101010", "0000001",
                     "0011000", "0001100", "1111010", "0100100", "1110000",
                     "1000001", "1100011", "1010101", "1001000", "1000100",
                     "0010010"};

   hex_letter_entry #(
      .DIGITS          (DIG),
      .DEBOUNCE_CYCLES (DB),
      .BLINK_CYCLES    (BL)
   ) dut (
      .CLOCK_50 (clk),
      .RESET    (rst),
      .KEY      (key),
      .HEX      (hex),
      .CODES    (codes),
      .CURSOR   (cursor)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [6:0] glyph(input int c);
      string s;
      logic [6:0] g;
      s = GL[c];
      for (int i = 0; i < 7; i++) g[i] = (s[i] == 8'h31);
      return g;
   endfunction

   function automatic logic [5*DIG-1:0] exp_codes();
      logic [5*DIG-1:0] v;
      for (int d = 0; d < DIG; d++) v[5*d +: 5] = 5'(m_slot[d]);
      return v;
   endfunction

   function automatic logic [7*DIG-1:0] exp_hex();
      logic [7*DIG-1:0] v;
      for (int d = 0; d < DIG; d++) v[7*d +: 7] = glyph(m_slot[d]);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int d = 0; d < DIG; d++) m_slot[d] = 0;
      m_cur = 0;
   endtask

   task automatic model_apply(input logic [2:0] m);
      if (m[0] && !m[1])      m_slot[m_cur] = m_slot[m_cur] % 25 + 1;
      else if (m[1] && !m[0]) m_slot[m_cur] = (m_slot[m_cur] <= 1) ? 25 : m_slot[m_cur] - 1;
      if (m[2]) m_cur = (m_cur + 1) % DIG;
   endtask

   task automatic press(input logic [2:0] m, input int hold, input int gap);
      key = ~m;
      repeat (hold) tick();
      key = 3'b111;
      repeat (gap) tick();
      model_apply(m);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      key = 3'b111;
      do_reset();
      checks++;
      if (hex !== 14'h3FFF) begin errors++; $display("FAIL reset_hex: got %h want 3fff", hex); end
      checks++;
      if (codes !== '0) begin errors++; $display("FAIL reset_codes: got %h want 0", codes); end
      checks++;
      if (cursor !== 1'b0) begin errors++; $display("FAIL reset_cursor: got %0d want 0", cursor); end
   endtask

   // First low sample is edge k; CODES at k+7, HEX at k+8.
   task automatic test_latency();
      key = 3'b110;
      for (int t = 1; t <= 10; t++) begin
         tick();
         if (t == 7) begin
            checks++;
            if (codes !== '0) begin errors++; $display("FAIL lat_codes_early: got %h want 0", codes); end
         end
         if (t == 8) begin
            checks++;
            if (codes !== 10'd1) begin errors++; $display("FAIL lat_codes: got %h want 001", codes); end
            checks++;
            if (hex[6:0] !== 7'h7F) begin errors++; $display("FAIL lat_hex_early: got %h want 7f", hex[6:0]); end
         end
         if (t == 9) begin
            checks++;
            if (hex[6:0] !== glyph(1)) begin errors++; $display("FAIL lat_hex: got %b want %b", hex[6:0], glyph(1)); end
         end
      end
      key = 3'b111;
      repeat (12) tick();
      model_apply(3'b001);
   endtask

   task automatic test_glitch();
      for (int i = 0; i < 10; i++) begin
         key = 3'b110;
         repeat ($urandom_range(1, 3)) tick();
         key = 3'b111;
         repeat ($urandom_range(1, 3)) tick();
      end
      repeat (12) tick();
      checks++;
      if (codes !== exp_codes()) begin errors++; $display("FAIL glitch_codes: got %h want %h", codes, exp_codes()); end
      checks++;
      if (hex !== exp_hex()) begin errors++; $display("FAIL glitch_hex: got %h want %h", hex, exp_hex()); end
   endtask

   task automatic test_next_wrap();
      do_reset();
      for (int i = 0; i < 25; i++) press(3'b001, 8, 12);
      checks++;
      if (codes[4:0] !== 5'd25) begin errors++; $display("FAIL next_to_z: got %0d want 25", codes[4:0]); end
      checks++;
      if (hex[6:0] !== glyph(25)) begin errors++; $display("FAIL z_glyph: got %b want %b", hex[6:0], glyph(25)); end
      press(3'b001, 8, 12);
      checks++;
      if (codes[4:0] !== 5'd1) begin errors++; $display("FAIL next_wrap: got %0d want 1", codes[4:0]); end
   endtask

   task automatic test_prev_cursor();
      do_reset();
      press(3'b010, 8, 12);
      checks++;
      if (codes[4:0] !== 5'd25) begin errors++; $display("FAIL prev_blank: got %0d want 25", codes[4:0]); end
      press(3'b001, 8, 12);
      press(3'b010, 8, 12);
      checks++;
      if (codes[4:0] !== 5'd25) begin errors++; $display("FAIL prev_from_a: got %0d want 25", codes[4:0]); end
      press(3'b100, 8, 12);
      checks++;
      if (cursor !== 1'b1) begin errors++; $display("FAIL cursor_adv: got %0d want 1", cursor); end
      press(3'b001, 8, 12);
      checks++;
      if (codes !== {5'd1, 5'd25}) begin errors++; $display("FAIL slot1_edit: got %h want %h", codes, {5'd1, 5'd25}); end
      press(3'b100, 8, 12);
      checks++;
      if (cursor !== 1'b0) begin errors++; $display("FAIL cursor_wrap: got %0d want 0", cursor); end
   endtask

   task automatic test_simultaneous();
      logic [2:0] masks [3] = '{3'b011, 3'b101, 3'b111};
      for (int i = 0; i < 3; i++) begin
         press(masks[i], 8, 12);
         checks++;
         if (codes !== exp_codes()) begin errors++; $display("FAIL simul_codes[%0d]: got %h want %h", i, codes, exp_codes()); end
         checks++;
         if (cursor !== 1'(m_cur)) begin errors++; $display("FAIL simul_cursor[%0d]: got %0d want %0d", i, cursor, m_cur); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 30; i++) begin
         logic [2:0] m;
         m = 3'($urandom_range(1, 7));
         press(m, $urandom_range(4, 12), $urandom_range(10, 14));
         checks++;
         if (codes !== exp_codes()) begin errors++; $display("FAIL rand_codes[%0d]: got %h want %h", i, codes, exp_codes()); end
         checks++;
         if (cursor !== 1'(m_cur)) begin errors++; $display("FAIL rand_cursor[%0d]: got %0d want %0d", i, cursor, m_cur); end
         checks++;
         if (hex !== exp_hex()) begin errors++; $display("FAIL rand_hex[%0d]: got %h want %h", i, hex, exp_hex()); end
      end
   endtask

   task automatic test_reset_held();
      key = 3'b110;
      tick();
      tick();
      rst = 1'b1;
      tick();
      model_reset();
      checks++;
      if (codes !== '0 || cursor !== 1'b0 || hex !== 14'h3FFF) begin
         errors++;
         $display("FAIL reset_held_clear: codes %h cursor %0d hex %h want 0 0 3fff", codes, cursor, hex);
      end
      rst = 1'b0;
      for (int t = 1; t <= 9; t++) begin
         tick();
         if (t == 7) begin
            checks++;
            if (codes !== '0) begin errors++; $display("FAIL reset_held_early: got %h want 0", codes); end
         end
         if (t == 8) begin
            checks++;
            if (codes !== 10'd1) begin errors++; $display("FAIL reset_held_press: got %h want 001", codes); end
         end
         if (t == 9) begin
            checks++;
            if (hex[6:0] !== glyph(1)) begin errors++; $display("FAIL reset_held_hex: got %b want %b", hex[6:0], glyph(1)); end
         end
      end
      key = 3'b111;
      repeat (12) tick();
      model_apply(3'b001);
   endtask

`ifdef CURSOR_BLINK_EN
   task automatic test_blink();
      int nblank;
      int nvis;
      nblank = 0;
      nvis   = 0;
      for (int t = 0; t < 4 * BL; t++) begin
         tick();
         if (hex[7*m_cur +: 7] === 7'h7F) nblank++;
         else if (hex[7*m_cur +: 7] === glyph(m_slot[m_cur])) nvis++;
      end
      checks++;
      if (nblank == 0) begin errors++; $display("FAIL blink_off: blank cycles %0d want >0", nblank); end
      checks++;
      if (nvis == 0) begin errors++; $display("FAIL blink_on: visible cycles %0d want >0", nvis); end
   endtask
`else
   task automatic test_no_blink();
      for (int t = 0; t < 4 * BL; t++) begin
         tick();
         checks++;
         if (hex !== exp_hex()) begin errors++; $display("FAIL steady_hex[%0d]: got %h want %h", t, hex, exp_hex()); end
      end
   endtask
`endif

   initial begin
      rst = 1'b0;
      key = 3'b111;
      model_reset();
      test_reset();
      test_latency();
      test_glitch();
      test_next_wrap();
      test_prev_cursor();
      test_simultaneous();
      test_random();
      test_reset_held();
`ifdef CURSOR_BLINK_EN
      test_blink();
`else
      test_no_blink();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
